// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory load/store unit.
// Four byte-lane banks of 16k bytes each form one 64 KiB region.
package dmem_pkg;

    localparam int DMEM_LANES = 4;
    localparam int LANE_AW    = 14;
    localparam int DMEM_AW    = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] rdata;
    } rsp_t;

    function automatic logic [2:0] size_nbytes(size_e sz);
        unique case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_rotate.sv
// Byte<->lane rotation for stores and loads, plus load extension.
// Purely combinational; access byte k lives in lane (off+k)%4.
module dmem_lane_rotate
    import dmem_pkg::*;
(
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] lane_rdata,
    output logic [3:0]  lane_mask,
    output logic [31:0] lane_wdata,
    output logic [31:0] ld_data
);

    logic [2:0]  nb;
    logic [1:0]  lane;
    logic [31:0] raw;

    always_comb begin
        nb         = size_nbytes(size);
        lane       = '0;
        lane_mask  = '0;
        lane_wdata = '0;
        raw        = '0;
        for (int k = 0; k < DMEM_LANES; k++) begin
            lane = off + 2'(k);
            if (3'(k) < nb) begin
                lane_mask[lane]        = 1'b1;
                lane_wdata[8*lane +: 8] = st_data[8*k +: 8];
                raw[8*k +: 8]          = lane_rdata[8*lane +: 8];
            end
        end
    end

    always_comb begin
        unique case (size)
            SZ_BYTE: ld_data = {{24{raw[7] & ~is_unsigned}}, raw[7:0]};
            SZ_HALF: ld_data = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
            default: ld_data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store front-end: handshake, fault checks, lane addressing
// and the one-entry registered response slot.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE        = 32'h0000_0000,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_fault_o,
    output logic [55:0] lane_addr_o,
    output logic [3:0]  lane_wren_o,
    output logic [31:0] lane_wdata_o,
    input  logic [31:0] lane_rdata_i
);

    size_e               sz;
    logic [31:0]         rel;
    logic [1:0]          off;
    logic [LANE_AW-1:0]  widx;
    logic [2:0]          nbytes;
    logic [32:0]         last;
    logic                range_err;
    logic                mis_err;
    logic                fault;
    logic                accept;
    logic [3:0]          mask;
    logic [31:0]         ld_data;
    rsp_t                rsp_q;

    assign sz     = size_e'(req_size_i);
    assign rel    = req_addr_i - DMEM_BASE;
    assign off    = rel[1:0];
    assign widx   = rel[DMEM_AW-1:2];
    assign nbytes = size_nbytes(sz);
    assign last   = {1'b0, rel} + 33'(nbytes) - 33'd1;

    // Any bit above the region in the last byte means the access runs off the top.
    assign range_err = (req_addr_i < DMEM_BASE) || (|last[32:DMEM_AW]);
    assign mis_err   = !ALLOW_MISALIGNED &&
                       (((sz == SZ_HALF) && req_addr_i[0]) ||
                        ((sz == SZ_WORD) && (|req_addr_i[1:0])));
    assign fault     = (sz == SZ_ILL) || range_err || mis_err;

    assign req_ready_o = rst_ni && (!rsp_q.valid || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    for (genvar i = 0; i < DMEM_LANES; i++) begin : g_lane
        assign lane_addr_o[LANE_AW*i +: LANE_AW] =
            (2'(i) < off) ? widx + LANE_AW'(1) : widx;
    end

    dmem_lane_rotate u_rot (
        .off         (off),
        .size        (sz),
        .is_unsigned (req_unsigned_i),
        .st_data     (req_wdata_i),
        .lane_rdata  (lane_rdata_i),
        .lane_mask   (mask),
        .lane_wdata  (lane_wdata_o),
        .ld_data     (ld_data)
    );

    assign lane_wren_o = (accept && req_we_i && !fault) ? mask : 4'b0000;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q <= '0;
        end else if (accept) begin
            rsp_q.valid <= 1'b1;
            rsp_q.fault <= fault;
            rsp_q.rdata <= (fault || req_we_i) ? 32'h0 : ld_data;
        end else if (rsp_ready_i) begin
            rsp_q.valid <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_q.valid;
    assign rsp_fault_o = rsp_q.fault;
    assign rsp_rdata_o = rsp_q.rdata;

endmodule
